// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation controller for the on-chip comparator
// Samples, then resolves one bit per settle window MSB-first using the synchronized comparator.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic             sample,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam int IW = $clog2(WIDTH);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sar_adc_ctrl: SYNC_STAGES must be at least 2");
    end
    if (SETTLE_CYCLES < SYNC_STAGES + 1) begin : g_bad_settle
      $error("sar_adc_ctrl: SETTLE_CYCLES must be at least SYNC_STAGES + 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_TRIAL
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          bit_q, bit_d;
  logic [WIDTH-1:0]       code_q, code_d;
  logic [WIDTH-1:0]       dac_q, dac_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   sample_q, sample_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   cmp_s;
  logic                   last_cnt;
  logic [WIDTH-1:0]       trial_bit;
  logic [WIDTH-1:0]       next_bit;
  logic [WIDTH-1:0]       decided;

  assign cmp_s     = sync_q[SYNC_STAGES-1];
  assign last_cnt  = (cnt_q == CW'(SETTLE_CYCLES - 1));
  assign trial_bit = WIDTH'(1) << bit_q;
  assign next_bit  = WIDTH'(1) << (bit_q - IW'(1));
  // code_q holds only already-resolved bits; the bit under trial is never stored there
  assign decided   = cmp_s ? (code_q | trial_bit) : code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      code_q   <= '0;
      dac_q    <= '0;
      result_q <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      code_q   <= code_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    code_d   = code_q;
    dac_d    = dac_q;
    result_d = result_q;
    sample_d = sample_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SAMPLE;
          cnt_d    = '0;
          code_d   = '0;
          dac_d    = '0;
          busy_d   = 1'b1;
          sample_d = 1'b1;
        end
      end
      S_SAMPLE: begin
        if (last_cnt) begin
          state_d  = S_TRIAL;
          cnt_d    = '0;
          bit_d    = IW'(WIDTH - 1);
          sample_d = 1'b0;
          dac_d    = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_TRIAL: begin
        if (last_cnt) begin
          cnt_d  = '0;
          code_d = decided;
          if (bit_q == '0) begin
            state_d  = S_IDLE;
            result_d = decided;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            dac_d    = '0;
          end else begin
            bit_d = bit_q - IW'(1);
            dac_d = decided | next_bit;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dac_code = dac_q;
  assign sample   = sample_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - directed bench for sar_adc_ctrl
// Comparator modes: 0 ideal, 1 stuck high, 2 stuck low, 3 glitching, 4 random.
module tb_sar_adc_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cmp_in;
  logic [7:0] dac_code;
  logic       sample;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int total;
  int bad;
  int mode;
  int analog;
  int k;
  int codes_173 [8] = '{128, 192, 160, 176, 168, 172, 174, 173};

  sar_adc_ctrl #(
    .WIDTH        (8),
    .SETTLE_CYCLES(4),
    .SYNC_STAGES  (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cmp_in  (cmp_in),
    .dac_code(dac_code),
    .sample  (sample),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_cmp();
    logic correct;
    correct = (analog >= int'(dac_code));
    case (mode)
      0: cmp_in = correct;
      1: cmp_in = 1'b1;
      2: cmp_in = 1'b0;
      3: cmp_in = ((k % 4) == 0) ? ~correct : correct;
      default: cmp_in = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Advance one edge, then settle the comparator model 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    drive_cmp();
  endtask

  task automatic conv(input string tag, input int mode_v, input int analog_v, input int exp_res,
                      input bit chk_codes, input bit hold_start, input int pulse_at);
    bit early;
    bit bad_sample;
    int exp_code;
    mode   = mode_v;
    analog = analog_v;
    start  = 1'b1;
    k      = -1;
    tick();
    start = hold_start;
    chk({tag, "_e0_busy"}, busy, 1);
    chk({tag, "_e0_sample"}, sample, 1);
    chk({tag, "_e0_dac"}, dac_code, 0);
    early      = 1'b0;
    bad_sample = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (c == pulse_at) start = 1'b1;
      if (c == pulse_at + 1) start = hold_start;
      tick();
      if (done !== 1'b0 || busy !== 1'b1) early = 1'b1;
      if (sample !== (c < 4)) bad_sample = 1'b1;
      if (chk_codes) begin
        exp_code = (c < 4) ? 0 : codes_173[(c - 4) / 4];
        chk($sformatf("%s_code_e%0d", tag, c), dac_code, exp_code);
      end
    end
    chk({tag, "_busy_no_early_done"}, early, 0);
    chk({tag, "_sample_window"}, bad_sample, 0);
    start = hold_start;
    tick();
    chk({tag, "_e36_done"}, done, 1);
    chk({tag, "_e36_busy"}, busy, 0);
    chk({tag, "_e36_result"}, result, exp_res);
    chk({tag, "_e36_dac"}, dac_code, 0);
  endtask

  initial begin
    int n_done;
    bit saw_done;
    total  = 0;
    bad    = 0;
    mode   = 0;
    analog = 0;
    k      = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    cmp_in = 1'b0;

    repeat (3) @(posedge clk);
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_sample", sample, 0);
    chk("rst_done", done, 0);
    chk("rst_dac", dac_code, 0);
    chk("rst_result", result, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", busy, 0);

    conv("ideal173", 0, 173, 173, 1'b1, 1'b0, -1);
    tick();
    chk("ideal173_e37_done", done, 0);
    chk("ideal173_e37_result_held", result, 173);

    conv("stuck1", 1, 0, 255, 1'b0, 1'b0, -1);
    tick();
    conv("stuck0", 2, 0, 0, 1'b0, 1'b0, -1);
    tick();

    conv("midpulse", 0, 200, 200, 1'b0, 1'b0, 10);
    tick();

    // start held high: next conversion must be accepted in the done cycle
    conv("hold1", 1, 0, 255, 1'b0, 1'b1, -1);
    tick();
    chk("hold_accept_busy", busy, 1);
    chk("hold_accept_sample", sample, 1);
    chk("hold_accept_done", done, 0);
    n_done = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1 && n_done == 0) n_done = i;
    end
    chk("hold_second_done_edge", n_done, 36);
    start = 1'b0;
    tick();

    // Reset mid-cycle during the bit-4 trial, with random comparator and start
    mode   = 4;
    start  = 1'b1;
    k      = -1;
    tick();
    start = 1'b0;
    while (k < 17) tick();
    chk("abort_busy_before", busy, 1);
    #2;
    start = 1'($urandom_range(0, 1));
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sample", sample, 0);
    chk("abort_dac", dac_code, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    repeat (2) tick();
    start = 1'b0;
    #2;
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || dac_code !== 8'd0) saw_done = 1'b1;
    end
    chk("abort_quiet_after_release", saw_done, 0);

    conv("post_abort90", 0, 90, 90, 1'b0, 1'b0, -1);
    tick();

    conv("glitch173", 3, 173, 173, 1'b0, 1'b0, -1);
    tick();
    chk("glitch_done_clear", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
